// File: rtl/bsg_clk_gen_tag_sequencer.sv
// Bit-serial bsg_tag master for the clock-generator domain: flushes the chain,
// runs the fixed reset/select/downsample init program, then forwards host packets.
module bsg_clk_gen_tag_sequencer #(
  parameter int num_clk_endpoint_p = 1,
  parameter int node_id_width_p    = 4,
  parameter int payload_width_p    = 8,
  parameter int len_width_p        = $clog2(payload_width_p + 1),
  parameter int ds_width_p         = 8,
  parameter int sel_width_p        = 2,
  parameter int flush_zeros_p      = 4,
  parameter int async_reset_node_p = 0,
  parameter int sel_node_base_p    = 1,
  parameter int ds_node_base_p     = 5,
  parameter int sel_init_p         = 0,
  parameter int ds_init_p          = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [node_id_width_p-1:0] node_id_i,
  input  logic                       data_not_reset_i,
  input  logic [len_width_p-1:0]     len_i,
  input  logic [payload_width_p-1:0] payload_i,
  output logic                       ready_o,
  output logic                       tag_data_o,
  output logic                       init_done_o
);

  localparam int hdr_bits_lp = 2 + node_id_width_p + len_width_p;
  localparam int num_pkts_lp = 2 + 2 * num_clk_endpoint_p;
  localparam int bit_w_lp    = $clog2(hdr_bits_lp + payload_width_p + 1);
  localparam int flush_w_lp  = (flush_zeros_p > 1) ? $clog2(flush_zeros_p) : 1;
  localparam int pkt_w_lp    = $clog2(num_pkts_lp);

  localparam logic [flush_w_lp-1:0] flush_last_lp = flush_w_lp'(flush_zeros_p - 1);
  localparam logic [pkt_w_lp-1:0]   pkt_last_lp   = pkt_w_lp'(num_pkts_lp - 1);

  typedef enum logic [1:0] {FLUSH, INIT, IDLE, SEND} state_e;

  typedef struct packed {
    logic [node_id_width_p-1:0] node;
    logic                       dnr;
    logic [len_width_p-1:0]     len;
    logic [payload_width_p-1:0] payload;
  } pkt_s;

  function automatic logic [len_width_p-1:0] sat_len(input logic [len_width_p-1:0] len);
    if (int'(len) > payload_width_p) return len_width_p'(payload_width_p);
    return len;
  endfunction

  // Program order: reset assert, (sel, ds) per endpoint, reset deassert.
  function automatic pkt_s prog_pkt(input int p);
    pkt_s pk;
    int   ep;
    ep     = (p - 1) / 2;
    pk.dnr = 1'b1;
    if (p == 0 || p == num_pkts_lp - 1) begin
      pk.node    = node_id_width_p'(async_reset_node_p);
      pk.len     = len_width_p'(1);
      pk.payload = payload_width_p'((p == 0) ? 1 : 0);
    end else if (((p - 1) % 2) == 0) begin
      pk.node    = node_id_width_p'(sel_node_base_p + ep);
      pk.len     = len_width_p'(sel_width_p);
      pk.payload = payload_width_p'(sel_init_p);
    end else begin
      pk.node    = node_id_width_p'(ds_node_base_p + ep);
      pk.len     = len_width_p'(ds_width_p);
      pk.payload = payload_width_p'(ds_init_p);
    end
    return pk;
  endfunction

  // Index hdr_bits_lp + len is the trailing gap, which falls through to 0.
  function automatic logic pkt_bit(input pkt_s pk, input int idx);
    int                         off;
    logic [node_id_width_p-1:0] nsh;
    logic [len_width_p-1:0]     lsh;
    logic [payload_width_p-1:0] psh;
    if (idx == 0) return 1'b1;
    off = idx - 1;
    if (off < node_id_width_p) begin
      nsh = pk.node >> off;
      return nsh[0];
    end
    off = off - node_id_width_p;
    if (off == 0) return pk.dnr;
    off = off - 1;
    if (off < len_width_p) begin
      lsh = pk.len >> off;
      return lsh[0];
    end
    off = off - len_width_p;
    if (off < int'(pk.len)) begin
      psh = pk.payload >> off;
      return psh[0];
    end
    return 1'b0;
  endfunction

  state_e                state_r, state_n;
  logic [flush_w_lp-1:0] flush_cnt_r, flush_cnt_n;
  logic [pkt_w_lp-1:0]   pkt_cnt_r, pkt_cnt_n;
  logic [bit_w_lp-1:0]   bit_idx_r, bit_idx_n;
  pkt_s                  pkt_r, pkt_n;
  logic                  pkt_done;
  logic                  tag_n;

  // State and counters describe the bit visible on tag_data_o this cycle.
  always_comb begin
    state_n     = state_r;
    flush_cnt_n = flush_cnt_r;
    pkt_cnt_n   = pkt_cnt_r;
    bit_idx_n   = bit_idx_r;
    pkt_n       = pkt_r;
    pkt_done    = (int'(bit_idx_r) == hdr_bits_lp + int'(pkt_r.len));
    unique case (state_r)
      FLUSH: begin
        if (flush_cnt_r == flush_last_lp) begin
          state_n   = INIT;
          pkt_cnt_n = '0;
          bit_idx_n = '0;
          pkt_n     = prog_pkt(0);
        end else begin
          flush_cnt_n = flush_cnt_r + 1'b1;
        end
      end
      INIT: begin
        if (!pkt_done) begin
          bit_idx_n = bit_idx_r + 1'b1;
        end else if (pkt_cnt_r == pkt_last_lp) begin
          state_n = IDLE;
        end else begin
          pkt_cnt_n = pkt_cnt_r + 1'b1;
          bit_idx_n = '0;
          pkt_n     = prog_pkt(int'(pkt_cnt_r) + 1);
        end
      end
      IDLE: begin
        if (v_i) begin
          state_n       = SEND;
          bit_idx_n     = '0;
          pkt_n.node    = node_id_i;
          pkt_n.dnr     = data_not_reset_i;
          pkt_n.len     = sat_len(len_i);
          pkt_n.payload = payload_i;
        end
      end
      SEND: begin
        if (!pkt_done) bit_idx_n = bit_idx_r + 1'b1;
        else           state_n   = IDLE;
      end
      default: state_n = FLUSH;
    endcase
    tag_n = ((state_n == INIT) || (state_n == SEND)) ? pkt_bit(pkt_n, int'(bit_idx_n)) : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= FLUSH;
      flush_cnt_r <= '0;
      pkt_cnt_r   <= '0;
      bit_idx_r   <= '0;
      tag_data_o  <= 1'b0;
      init_done_o <= 1'b0;
    end else begin
      state_r     <= state_n;
      flush_cnt_r <= flush_cnt_n;
      pkt_cnt_r   <= pkt_cnt_n;
      bit_idx_r   <= bit_idx_n;
      tag_data_o  <= tag_n;
      init_done_o <= init_done_o | (state_n == IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    pkt_r <= pkt_n;
  end

  assign ready_o = (state_r == IDLE);

endmodule

// File: tb/tb_bsg_clk_gen_tag_sequencer.sv
// Randomized bench: expected tag bit streams are built from the packet format
// rules and consumed one bit per cycle alongside the two DUT instances.
module tb_bsg_clk_gen_tag_sequencer;
  localparam int NW = 4;
  localparam int PW = 8;
  localparam int LW = 4;
  localparam int F  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i, v_i, dnr_i;
  logic [3:0] node_i, len_i;
  logic [7:0] payload_i;
  logic       ready, tag, done;
  logic       ready2, tag2, done2;

  bsg_clk_gen_tag_sequencer u_dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .node_id_i(node_i),
    .data_not_reset_i(dnr_i), .len_i(len_i), .payload_i(payload_i),
    .ready_o(ready), .tag_data_o(tag), .init_done_o(done)
  );

  bsg_clk_gen_tag_sequencer #(.num_clk_endpoint_p(2), .sel_init_p(1), .ds_init_p(3)) u_dut2 (
    .clk_i(clk), .reset_i(reset_i), .v_i(1'b0), .node_id_i(4'd0),
    .data_not_reset_i(1'b0), .len_i(4'd0), .payload_i(8'd0),
    .ready_o(ready2), .tag_data_o(tag2), .init_done_o(done2)
  );

  int   errors = 0;
  int   checks = 0;
  bit   q1[$];
  bit   q2[$];
  bit   pk[$];
  bit   done1_m, done2_m;
  int   cyc;
  int   first_acc = -1;
  logic last_tag, last_ready, last_done;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Start bit, node LSB first, dnr, saturated length LSB first, payload, gap.
  task automatic make_pkt(input int node, input int dnr, input int len, input int pl);
    int l;
    l = (len > PW) ? PW : len;
    pk.delete();
    pk.push_back(1'b1);
    for (int i = 0; i < NW; i++) pk.push_back(bit'((node >> i) & 1));
    pk.push_back(bit'(dnr & 1));
    for (int i = 0; i < LW; i++) pk.push_back(bit'((l >> i) & 1));
    for (int i = 0; i < l; i++) pk.push_back(bit'((pl >> i) & 1));
    pk.push_back(1'b0);
  endtask

  task automatic append(input int which);
    foreach (pk[i]) begin
      if (which == 1) q1.push_back(pk[i]);
      else            q2.push_back(pk[i]);
    end
  endtask

  task automatic load_init(input int which, input int ne, input int seli, input int dsi);
    pk.delete();
    for (int i = 0; i < F; i++) pk.push_back(1'b0);
    append(which);
    make_pkt(0, 1, 1, 1);
    append(which);
    for (int e = 0; e < ne; e++) begin
      make_pkt(1 + e, 1, 2, seli);
      append(which);
      make_pkt(5 + e, 1, 8, dsi);
      append(which);
    end
    make_pkt(0, 1, 1, 0);
    append(which);
  endtask

  task automatic step();
    bit er1, er2, et1, et2;
    @(negedge clk);
    er1 = (q1.size() == 0);
    et1 = er1 ? 1'b0 : q1.pop_front();
    if (er1) done1_m = 1'b1;
    er2 = (q2.size() == 0);
    et2 = er2 ? 1'b0 : q2.pop_front();
    if (er2) done2_m = 1'b1;
    check_val("tag", tag, et1);
    check_val("ready", ready, er1);
    check_val("init_done", done, done1_m);
    check_val("tag2", tag2, et2);
    check_val("ready2", ready2, er2);
    check_val("init_done2", done2, done2_m);
    last_tag   = tag;
    last_ready = ready;
    last_done  = done;
    if (reset_i) begin
      q1.delete();
      q2.delete();
      done1_m = 1'b0;
      done2_m = 1'b0;
      load_init(1, 1, 0, 0);
      load_init(2, 2, 1, 3);
      cyc = 0;
    end else begin
      if (er1 && v_i) begin
        if (first_acc < 0) first_acc = cyc;
        make_pkt(int'(node_i), int'(dnr_i), int'(len_i), int'(payload_i));
        append(1);
      end
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    node_i    = 4'($urandom_range(0, 15));
    dnr_i     = 1'($urandom_range(0, 1));
    len_i     = 4'($urandom_range(0, 15));
    payload_i = 8'($urandom_range(0, 255));
  endtask

  task automatic directed(input int node, input int len, input int pl, input int nbits);
    node_i    = 4'(node);
    dnr_i     = 1'b1;
    len_i     = 4'(len);
    payload_i = 8'(pl);
    v_i       = 1'b1;
    step();
    v_i = 1'b0;
    rand_fields();
    repeat (nbits + 1) step();
    check_val("busy_before_ready", last_ready, 0);
    step();
    check_val("ready_after_gap", last_ready, 1);
  endtask

  logic [18:0] cap;

  initial begin
    reset_i = 1'b1;
    v_i = 1'b0; node_i = '0; dnr_i = 1'b0; len_i = '0; payload_i = '0;
    cyc = 0; done1_m = 1'b0; done2_m = 1'b0;
    @(posedge clk);
    #1;
    load_init(1, 1, 0, 0);
    load_init(2, 2, 1, 3);
    repeat (2) step();
    check_val("reset_tag", last_tag, 0);
    check_val("reset_ready", last_ready, 0);
    check_val("reset_done", last_done, 0);
    reset_i = 1'b0;

    // Valid held through flush/init, then back-to-back packets with churning fields.
    v_i = 1'b1;
    for (int k = 0; k < 150; k++) begin
      rand_fields();
      step();
    end
    check_val("first_accept_cycle", first_acc, 60);
    v_i = 1'b0;
    repeat (25) step();

    node_i = 4'd3; dnr_i = 1'b1; len_i = 4'd8; payload_i = 8'hA5; v_i = 1'b1;
    step();
    v_i = 1'b0;
    rand_fields();
    cap = '0;
    for (int k = 0; k < 19; k++) begin
      step();
      cap = {cap[17:0], last_tag};
    end
    check_val("a5_bits", cap, 19'b1110010001101001010);
    step();
    check_val("a5_ready", last_ready, 1);

    directed(9, 0, 8'hFF, 10);
    directed(6, 15, 8'h3C, 18);

    for (int k = 0; k < 300; k++) begin
      rand_fields();
      v_i = 1'($urandom_range(0, 1));
      step();
    end
    v_i = 1'b0;
    repeat (25) step();

    // Reset pulse in the middle of the downsample packet (cycles 29..47).
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    repeat (35) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    check_val("midreset_tag", last_tag, 0);
    check_val("midreset_done", last_done, 0);
    repeat (110) step();
    check_val("replay_done", last_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
